timer_counter: RTL and testbench
================================

// Module: timer_counter
// PURPOSE
// Programmable interval timer on the processor bridge, downstream of the
// mips core: it decodes PrAddr/PrWData/PrWrite word accesses, returns
// PrRData, and drives one HWInt[7:2] line. It loads a preset value, counts
// down to zero and raises an interrupt, either once (mode 0) or periodically
// with auto-reload (mode 1). The bridge handles address decode and routes
// IRQ to HWInt[2].
// PARAMETERS
// WIDTH  32  width of PRESET/COUNT registers; CTRL is always 4 bits, zero-extended
// PORTS
// Clk    in   1      system clock; all state changes on rising edge
// Rst    in   1      asynchronous, active-high reset
// Addr   in   2      register select (PrAddr[3:2]): 0 CTRL, 1 PRESET, 2 COUNT, 3 reserved
// WE     in   1      write strobe (bridge-qualified PrWrite && device select)
// WData  in   32     write data (full word; byte masks not supported)
// RData  out  32     read data, combinational from Addr and current registers
// IRQ    out  1      interrupt request to HWInt, level in mode 0, 1-cycle pulse in mode 1
// BEHAVIOUR
// - Reset: CTRL=0, PRESET=0, COUNT=0, irq_flag=0, state=IDLE, IRQ=0, RData=0 for Addr 0/1/2.
// - CTRL bits: [0] En, [2:1] Mode (2'b00 one-shot, 2'b01 periodic, 2'b1x act as 00), [3] IM.
//   CTRL[31:4] read 0 and ignore writes.
// - Writes: Addr0 -> CTRL[3:0]; Addr1 -> PRESET; Addr2/3 ignored. Any write to Addr0 or
//   Addr1 clears irq_flag. Registers update at the edge ending the WE cycle.
// - Reads: Addr0 {28'b0,CTRL}, Addr1 PRESET, Addr2 COUNT, Addr3 0. WIDTH<32 zero-extends.
// - FSM (registered state, 2 bits):
//   IDLE: En=1 -> LOAD; else stay, COUNT held.
//   LOAD: COUNT<=PRESET -> CNT.
//   CNT : En=0 -> IDLE (COUNT frozen). COUNT==0 -> INT. Otherwise COUNT<=COUNT-1.
//   INT : mode 0: irq_flag<=1, CTRL.En<=0 -> IDLE.
//         mode 1: -> LOAD (reload, irq_flag untouched).
// - IRQ = IM & ((mode0 & irq_flag) | (mode1 & state==INT)). Combinational from registers only.
// - Latency: En written in cycle t, LOAD in t+1, COUNT=P in t+2, COUNT=0 in t+2+P,
//   INT in t+3+P.
// - Period: mode 1 asserts IRQ every P+3 cycles.
// - PRESET=0: LOAD->CNT->INT; no underflow. COUNT never decrements below 0
//   and never wraps.
// - PRESET write while counting: no effect until the next LOAD.
// - En cleared mid-count: count stops. Re-enabling goes IDLE->LOAD and reloads from PRESET.
// - Same-cycle conflicts: software write of CTRL.En beats hardware clear in INT.
//   Hardware set of irq_flag beats software clear.
// - Mode changed while counting: takes effect at the next INT evaluation.
// - Rst asserted mid-count: immediate return to reset values; IRQ drops asynchronously.
// TESTING
// - Reset mid-count (COUNT=5, IRQ=1) -> all regs 0 and IRQ=0 with no clock edge.
//   After release, read Addr0/1/2 = 0.
// - PRESET=3, CTRL=4'b1001 (one-shot, IM, En) written at t -> COUNT reads 3,2,1,0
//   at t+2..t+5. IRQ=1 from t+7 (INT at t+6) and stays high; CTRL reads 4'b1000.
//   Write CTRL -> IRQ=0.
// - PRESET=2, CTRL=4'b1011 (periodic) -> IRQ 1-cycle pulses spaced 5 cycles apart,
//   COUNT reloads to 2. Clearing En -> pulses stop and COUNT freezes.
// - PRESET=0, one-shot, IM=1 -> IRQ high 3 cycles after the En write plus 1; COUNT stays 0.
// - PRESET=10, En=1, then PRESET=4 written while COUNT=7 -> count finishes from 7.
//   A second run (re-enable) loads 4.
// - IM=0 one-shot expiry -> IRQ stays 0, En cleared. Then write IM=1 to CTRL without
//   touching the flag path -> flag cleared by write, IRQ stays 0.
//   Write to Addr2 = 0xFFFF -> COUNT unchanged.

Source files
------------

// File: rtl/timer_counter.sv
// Programmable down-counting interval timer on the processor bridge: one-shot or periodic IRQ.
// Latency: En write -> LOAD next cycle, expiry P+3 cycles later; register reads are combinational; no backpressure.
module timer_counter #(
    parameter int WIDTH = 32
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [1:0]  Addr,
    input  logic        WE,
    input  logic [31:0] WData,
    output logic [31:0] RData,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } stateT;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    stateT            state;
    stateT            stateNext;
    logic [3:0]       ctrl;
    logic [WIDTH-1:0] preset;
    logic [WIDTH-1:0] count;
    logic             irqFlag;

    logic ctrlWr;
    logic presetWr;
    logic enEff;
    logic periodic;

    assign ctrlWr   = WE && (Addr == 2'd0);
    assign presetWr = WE && (Addr == 2'd1);
    // The FSM reacts to an En write in the same cycle it is written.
    assign enEff    = ctrlWr ? WData[0] : ctrl[0];
    assign periodic = (ctrl[2:1] == 2'b01);

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: if (enEff) stateNext = LOAD;
            LOAD: stateNext = CNT;
            CNT: begin
                if (!enEff)
                    stateNext = IDLE;
                else if (count == '0)
                    stateNext = INT;
            end
            INT:     stateNext = periodic ? LOAD : IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state   <= IDLE;
            ctrl    <= '0;
            preset  <= '0;
            count   <= '0;
            irqFlag <= 1'b0;
        end else begin
            state <= stateNext;

            // Software En write wins over the one-shot hardware clear.
            if (ctrlWr)
                ctrl <= WData[3:0];
            else if (state == INT && !periodic)
                ctrl[0] <= 1'b0;

            if (presetWr)
                preset <= WData[WIDTH-1:0];

            // Hardware set of the flag wins over the software clear.
            if (state == INT && !periodic)
                irqFlag <= 1'b1;
            else if (ctrlWr || presetWr)
                irqFlag <= 1'b0;

            if (state == LOAD)
                count <= preset;
            else if (state == CNT && enEff && count != '0)
                count <= count - ONE;
        end
    end

    always_comb begin
        RData = '0;
        case (Addr)
            2'd0:    RData = {28'b0, ctrl};
            2'd1:    RData = 32'(preset);
            2'd2:    RData = 32'(count);
            default: RData = '0;
        endcase
    end

    assign IRQ = ctrl[3] & ((!periodic & irqFlag) | (periodic & (state == INT)));

endmodule

// File: tb/tb_timer_counter.sv
// Directed-vector bench for timer_counter: hand-computed register and IRQ timing.
module tb_timer_counter;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [1:0]  Addr;
    logic        WE;
    logic [31:0] WData;
    logic [31:0] RData;
    logic        IRQ;

    int nVec  = 0;
    int nMiss = 0;

    timer_counter #(.WIDTH(32)) dut (
        .Clk   (Clk),
        .Rst   (Rst),
        .Addr  (Addr),
        .WE    (WE),
        .WData (WData),
        .RData (RData),
        .IRQ   (IRQ)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nVec++;
        if (got !== exp) begin
            nMiss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic checkIrq(input string tag, input logic exp);
        check(tag, {31'b0, IRQ}, {31'b0, exp});
    endtask

    // Called at a negedge: holds the write for the current cycle, returns at the next negedge.
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        Addr  = a;
        WData = d;
        WE    = 1'b1;
        @(negedge Clk);
        WE    = 1'b0;
        WData = '0;
    endtask

    task automatic checkReg(input string tag, input logic [1:0] a, input logic [31:0] exp);
        Addr = a;
        #1;
        check(tag, RData, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge Clk);
    endtask

    initial begin
        Rst = 1'b1; WE = 1'b0; Addr = 2'd0; WData = '0;
        #1;
        checkIrq("reset irq", 1'b0);
        checkReg("reset ctrl", 2'd0, 32'h0);
        checkReg("reset preset", 2'd1, 32'h0);
        checkReg("reset count", 2'd2, 32'h0);
        tick(2);
        Rst = 1'b0;

        // Expiry and CTRL rewrite in the same cycle: flag set and En kept, then reset mid-count.
        wr(2'd1, 32'd6);
        wr(2'd0, 32'h9);                 // now t+1
        Addr = 2'd2;
        tick(8);                         // t+9, state INT
        checkIrq("t1 irq in int", 1'b0);
        wr(2'd0, 32'h9);                 // t+10
        checkIrq("t1 flag beats clear", 1'b1);
        checkReg("t1 en beats clear", 2'd0, 32'h9);
        Addr = 2'd2;
        tick(3);                         // t+13
        check("t1 count mid", RData, 32'd5);
        checkIrq("t1 irq mid", 1'b1);
        Rst = 1'b1;
        #1;
        checkIrq("t1 async irq drop", 1'b0);
        check("t1 async count", RData, 32'h0);
        checkReg("t1 async ctrl", 2'd0, 32'h0);
        checkReg("t1 async preset", 2'd1, 32'h0);
        @(negedge Clk);
        Rst = 1'b0;
        checkReg("t1 post ctrl", 2'd0, 32'h0);
        checkReg("t1 post preset", 2'd1, 32'h0);
        checkReg("t1 post count", 2'd2, 32'h0);
        @(negedge Clk);

        // One-shot, PRESET=3.
        wr(2'd1, 32'd3);
        wr(2'd0, 32'h9);                 // t+1
        Addr = 2'd2;
        for (int k = 2; k <= 5; k++) begin
            tick(1);
            check("t2 count", RData, 32'(5 - k));
        end
        tick(1);                         // t+6
        checkIrq("t2 irq at int", 1'b0);
        tick(1);                         // t+7
        checkIrq("t2 irq set", 1'b1);
        tick(1);
        checkIrq("t2 irq level", 1'b1);
        checkReg("t2 en cleared", 2'd0, 32'h8);
        checkReg("t2 count held", 2'd2, 32'h0);
        wr(2'd0, 32'h8);
        checkIrq("t2 irq cleared", 1'b0);

        // Periodic, PRESET=2: pulses at t+5, t+10, t+15.
        wr(2'd1, 32'd2);
        wr(2'd0, 32'hB);                 // t+1
        Addr = 2'd2;
        for (int k = 2; k <= 17; k++) begin
            tick(1);
            checkIrq("t3 pulse", (k == 5) || (k == 10) || (k == 15));
            if (k == 7)
                check("t3 reload", RData, 32'd2);
        end
        wr(2'd0, 32'hA);                 // clears En while COUNT=2
        Addr = 2'd2;
        for (int i = 0; i < 6; i++) begin
            #1;
            check("t3 frozen count", RData, 32'd2);
            checkIrq("t3 no pulse", 1'b0);
            tick(1);
        end

        // PRESET=0 one-shot.
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h9);                 // t+1
        Addr = 2'd2;
        tick(1);                         // t+2
        check("t4 count zero", RData, 32'h0);
        tick(1);                         // t+3
        checkIrq("t4 irq at int", 1'b0);
        tick(1);                         // t+4
        checkIrq("t4 irq set", 1'b1);
        check("t4 no underflow", RData, 32'h0);
        wr(2'd0, 32'h8);

        // PRESET rewritten mid-count.
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h9);                 // t+1
        Addr = 2'd2;
        tick(4);                         // t+5
        check("t5 count 7", RData, 32'd7);
        wr(2'd1, 32'd4);                 // t+6
        checkReg("t5 count continues", 2'd2, 32'd6);
        tick(6);                         // t+12
        check("t5 count done", RData, 32'h0);
        checkIrq("t5 irq early", 1'b0);
        tick(2);                         // t+14
        checkIrq("t5 irq set", 1'b1);
        wr(2'd0, 32'h9);                 // u+1
        checkIrq("t5 flag cleared", 1'b0);
        Addr = 2'd2;
        tick(1);                         // u+2
        check("t5 new preset loaded", RData, 32'd4);
        wr(2'd0, 32'h0);

        // IM=0 one-shot expiry, then IM set with a flag-clearing write.
        wr(2'd1, 32'd1);
        wr(2'd0, 32'h1);                 // t+1
        tick(4);                         // t+5
        checkIrq("t6 masked", 1'b0);
        checkReg("t6 en cleared", 2'd0, 32'h0);
        wr(2'd0, 32'h8);
        checkIrq("t6 flag cleared", 1'b0);
        checkReg("t6 ctrl", 2'd0, 32'h8);
        wr(2'd2, 32'hFFFF);
        checkReg("t6 count unwritable", 2'd2, 32'h0);
        checkReg("t6 reserved", 2'd3, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
        $finish;
    end

endmodule
